// File: rtl/modexp_arbiter_if.sv
// Requester-side bus of the modexp arbiter.
//
// Ports carried:
//   req          per-requester request level; held until the matching done bit
//   req_m/e/n    packed operands, slice k = [k*W +: W]
//   gnt          one-hot, 1-cycle pulse when a requester's operands are captured
//   done         one-hot, 1-cycle pulse when res is valid for that requester
//   res          result, held until the next done
//   busy         high whenever the arbiter FSM is not idle
//   owner        index of the current or last granted requester
//   last_cycles  length of the last operation, ISSUE through done inclusive
//
// Modports: master = requester side, slave = arbiter side.
interface modexp_arbiter_if #(
    parameter int W    = 2048,
    parameter int NREQ = 4,
    parameter int IDXW = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_m;
    logic [NREQ*W-1:0] req_e;
    logic [NREQ*W-1:0] req_n;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      res;
    logic              busy;
    logic [IDXW-1:0]   owner;
    logic [31:0]       last_cycles;

    modport master (
        output req, req_m, req_e, req_n,
        input  gnt, done, res, busy, owner, last_cycles
    );

    modport slave (
        input  req, req_m, req_e, req_n,
        output gnt, done, res, busy, owner, last_cycles
    );
endinterface

// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one modexp engine among NREQ requesters.
//
// The winner's operands are captured into holding registers at grant time so
// m/e/n stay stable for the whole engine run, the engine start/ready handshake
// is sequenced, and the result is returned with a one-hot done pulse.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   bus        requester bus (slave modport of modexp_arbiter_if)
//   eng_start  one-cycle engine start pulse
//   eng_ready  engine ready, high while the engine is idle
//   eng_m/e/n  latched operands to the engine
//   eng_c      engine result
module modexp_arbiter #(
    parameter int W    = 2048,
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    modexp_arbiter_if.slave       bus,
    output logic                  eng_start,
    input  logic                  eng_ready,
    output logic [W-1:0]          eng_m,
    output logic [W-1:0]          eng_e,
    output logic [W-1:0]          eng_n,
    input  logic [W-1:0]          eng_c
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   last;       // round-robin pointer: most recent winner
    logic [31:0]       cnt;        // cycles elapsed in the current operation
    logic [31:0]       cnt_inc;
    logic [NREQ-1:0]   req_eff;
    logic [IDXW-1:0]   cand;
    logic [IDXW-1:0]   pick;
    logic              found;
    logic              grant;
    logic              finish;

    // Round-robin pick: scan last+1, last+2, ... modulo NREQ.
    // The requester whose done is pulsing this cycle is masked out: it only
    // sees done now and drops req a cycle later, so it must not be regranted.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req_eff = bus.req & ~bus.done;
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(last) + i) % NREQ);
            if (!found && req_eff[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign grant   = (state == IDLE) && found && eng_ready;
    assign finish  = (state == WAIT_DONE) && eng_ready;
    assign cnt_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block order.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state and the combinational engine start.
    always_comb begin
        state_next = state;
        eng_start  = 1'b0;
        case (state)
            IDLE:      if (grant)      state_next = ISSUE;
            ISSUE: begin
                eng_start  = 1'b1;
                state_next = WAIT_BUSY;
            end
            // Engine dropping ready confirms it accepted the start.
            WAIT_BUSY: if (!eng_ready) state_next = WAIT_DONE;
            WAIT_DONE: if (eng_ready)  state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Operand capture, result return and cycle accounting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the wide operand/result holding registers are reset too,
            // because software may read res and the engine inputs right after
            // reset and must see zero rather than stale data.
            eng_m           <= '0;
            eng_e           <= '0;
            eng_n           <= '0;
            bus.res         <= '0;
            bus.gnt         <= '0;
            bus.done        <= '0;
            bus.owner       <= '0;
            bus.last_cycles <= '0;
            last            <= IDXW'(NREQ - 1);
            cnt             <= '0;
        end else begin
            bus.gnt  <= '0;
            bus.done <= '0;

            if (state != IDLE) cnt <= cnt_inc;

            if (grant) begin
                eng_m     <= bus.req_m[pick*W +: W];
                eng_e     <= bus.req_e[pick*W +: W];
                eng_n     <= bus.req_n[pick*W +: W];
                bus.owner <= pick;
                last      <= pick;
                bus.gnt   <= NREQ'(1) << pick;
                cnt       <= 32'd1;   // the ISSUE cycle is cycle 1
            end

            // The done cycle itself is counted, hence the increment here.
            if (finish) begin
                bus.res         <= eng_c;
                bus.done        <= NREQ'(1) << bus.owner;
                bus.last_cycles <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_modexp_arbiter.sv
// Self-checking bench for modexp_arbiter (W=16, NREQ=4) with a behavioural
// engine that drops ready on start and returns the result LAT cycles later.
module tb_modexp_arbiter;

    localparam int W    = 16;
    localparam int NREQ = 4;
    localparam int IDXW = 2;
    localparam int LAT  = 3;
    // ISSUE .. done inclusive for this engine model
    localparam logic [31:0] OP_CYCLES = 32'(LAT + 3);

    logic           clk;
    logic           rst;
    logic           eng_start;
    logic           eng_ready;
    logic [W-1:0]   eng_m, eng_e, eng_n;
    logic [W-1:0]   eng_c;

    modexp_arbiter_if #(.W(W), .NREQ(NREQ), .IDXW(IDXW)) bus ();

    modexp_arbiter #(.W(W), .NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .eng_start (eng_start),
        .eng_ready (eng_ready),
        .eng_m     (eng_m),
        .eng_e     (eng_e),
        .eng_n     (eng_n),
        .eng_c     (eng_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_start = 0;
    int n_done_total = 0;
    int proto_err = 0;

    always @(posedge clk) cyc++;

    // ---------------- engine model ----------------
    logic        eng_rdy_m = 1'b1;
    logic        eng_block = 1'b0;
    bit          running   = 1'b0;
    int          ecnt      = 0;
    logic [W-1:0] eresult  = '0;

    initial eng_c = '0;
    assign eng_ready = eng_rdy_m & ~eng_block;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] m, e, n);
        longint r, b;
        if (n == 0) return '0;
        b = longint'(m) % longint'(n);
        r = 1 % longint'(n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return r[W-1:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            eng_rdy_m = 1'b1;
            running   = 1'b0;
        end else if (running) begin
            if (ecnt == 0) begin
                eng_c     = eresult;
                eng_rdy_m = 1'b1;
                running   = 1'b0;
            end else begin
                ecnt--;
            end
        end else if (eng_start && eng_ready) begin
            eresult   = modexp(eng_m, eng_e, eng_n);
            ecnt      = LAT;
            running   = 1'b1;
            eng_rdy_m = 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    always @(negedge clk) begin
        if (eng_start) n_start++;
        if (bus.done != 0) n_done_total++;
        if (!$onehot0(bus.gnt) || !$onehot0(bus.done)) proto_err++;
        if ((bus.gnt != 0) && (bus.done != 0)) proto_err++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] m, e, n);
        bus.req_m[idx*W +: W] = m;
        bus.req_e[idx*W +: W] = e;
        bus.req_n[idx*W +: W] = n;
    endtask

    // Advance until gnt (want_done=0) or done (want_done=1) is non-zero.
    task automatic wait_sig(input bit want_done, input int budget, output logic [NREQ-1:0] val);
        val = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            val = want_done ? bus.done : bus.gnt;
            if (val != 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got none within %0d cycles, expected a pulse",
                 want_done ? "done" : "gnt", budget);
    endtask

    typedef struct {
        int          idx;
        logic [W-1:0] m;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic [W-1:0] res;
        bit          alter;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] acc;
        int c0, s0, d_snap, d_cyc;
        int g_ord[$], g_cyc[$], dn_ord[$], dn_cyc[$];
        logic [W-1:0] res1;

        vecs[0] = '{0, 16'd4,  16'd13, 16'd497,  16'd445, 1'b0};
        vecs[1] = '{0, 16'd4,  16'd13, 16'd497,  16'd445, 1'b1};
        vecs[2] = '{2, 16'd3,  16'd5,  16'd100,  16'd43,  1'b0};
        vecs[3] = '{3, 16'd10, 16'd2,  16'd7,    16'd2,   1'b0};
        vecs[4] = '{1, 16'd5,  16'd3,  16'd13,   16'd8,   1'b0};
        vecs[5] = '{2, 16'd7,  16'd0,  16'd13,   16'd1,   1'b0};
        vecs[6] = '{1, 16'd12, 16'd3,  16'd19,   16'd18,  1'b1};

        rst       = 1'b0;
        bus.req   = '0;
        bus.req_m = '0;
        bus.req_e = '0;
        bus.req_n = '0;
        repeat (3) tick();

        // ---- reset values ----
        check("rst_gnt",   32'(bus.gnt), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_start", 32'(eng_start), 0);
        check("rst_res",   32'(bus.res), 0);
        check("rst_owner", 32'(bus.owner), 0);
        check("rst_lastc", bus.last_cycles, 0);
        check("rst_eng_m", 32'(eng_m), 0);
        rst = 1'b1;
        tick();

        // ---- three simultaneous requests: grants in pointer order 0,1,2 ----
        set_ops(0, 16'd4, 16'd13, 16'd497);
        set_ops(1, 16'd2, 16'd10, 16'd1000);
        set_ops(2, 16'd3, 16'd5,  16'd100);
        bus.req = 4'b0111;
        c0 = cyc;
        res1 = '0;
        for (int i = 0; i < 200 && dn_ord.size() < 3; i++) begin
            tick();
            if (bus.gnt != 0) begin
                g_ord.push_back(int'(bus.gnt));
                g_cyc.push_back(cyc);
            end
            if (bus.done != 0) begin
                dn_ord.push_back(int'(bus.done));
                dn_cyc.push_back(cyc);
                if (bus.done[1]) res1 = bus.res;
                bus.req = bus.req & ~bus.done;
            end
        end
        check("multi_ngnt",  32'(g_ord.size()), 3);
        check("multi_ndone", 32'(dn_ord.size()), 3);
        if (g_ord.size() == 3 && dn_ord.size() == 3) begin
            check("multi_gnt0",  32'(g_ord[0]), 1);
            check("multi_gnt1",  32'(g_ord[1]), 2);
            check("multi_gnt2",  32'(g_ord[2]), 4);
            check("multi_done0", 32'(dn_ord[0]), 1);
            check("multi_done1", 32'(dn_ord[1]), 2);
            check("multi_done2", 32'(dn_ord[2]), 4);
            check("multi_lat",   32'(g_cyc[0] - c0), 1);
            check("multi_gap1",  32'(g_cyc[1] - dn_cyc[0]), 1);
            check("multi_gap2",  32'(g_cyc[2] - dn_cyc[1]), 1);
        end
        check("multi_res1", 32'(res1), 32'd24);
        bus.req = '0;
        tick();

        // ---- table-driven single operations ----
        foreach (vecs[k]) begin
            set_ops(vecs[k].idx, vecs[k].m, vecs[k].e, vecs[k].n);
            s0 = n_start;
            bus.req = NREQ'(1) << vecs[k].idx;
            tick();
            check($sformatf("v%0d_gnt", k),   32'(bus.gnt), 32'(1) << vecs[k].idx);
            check($sformatf("v%0d_owner", k), 32'(bus.owner), 32'(vecs[k].idx));
            check($sformatf("v%0d_busy", k),  32'(bus.busy), 1);
            check($sformatf("v%0d_eng_m", k), 32'(eng_m), 32'(vecs[k].m));
            check($sformatf("v%0d_eng_n", k), 32'(eng_n), 32'(vecs[k].n));
            if (vecs[k].alter) bus.req_m[vecs[k].idx*W +: W] = ~vecs[k].m;
            wait_sig(1'b1, 50, v);
            check($sformatf("v%0d_done", k),  32'(v), 32'(1) << vecs[k].idx);
            check($sformatf("v%0d_res", k),   32'(bus.res), 32'(vecs[k].res));
            check($sformatf("v%0d_lastc", k), bus.last_cycles, OP_CYCLES);
            check($sformatf("v%0d_idle", k),  32'(bus.busy), 0);
            check($sformatf("v%0d_hold_m", k), 32'(eng_m), 32'(vecs[k].m));
            check($sformatf("v%0d_starts", k), 32'(n_start - s0), 1);
            bus.req = '0;
            tick();
        end

        // ---- round robin: held req 0 yields to newly arrived req 3 ----
        set_ops(0, 16'd4,  16'd13, 16'd497);
        set_ops(3, 16'd10, 16'd2,  16'd7);
        bus.req = 4'b0001;
        tick();
        check("rr_gnt0", 32'(bus.gnt), 1);
        tick();
        bus.req = 4'b1001;
        wait_sig(1'b1, 50, v);
        check("rr_done0", 32'(v), 1);
        d_cyc = cyc;
        wait_sig(1'b0, 10, v);
        check("rr_next_is_3", 32'(v), 32'h8);
        check("rr_gap", 32'(cyc - d_cyc), 1);
        wait_sig(1'b1, 50, v);
        check("rr_done3", 32'(v), 32'h8);
        check("rr_res3", 32'(bus.res), 2);
        bus.req = 4'b0001;
        wait_sig(1'b0, 10, v);
        check("rr_back_to_0", 32'(v), 1);
        wait_sig(1'b1, 50, v);
        check("rr_res0", 32'(bus.res), 32'd445);
        bus.req = '0;
        tick();

        // ---- engine not ready: no grant until it is released ----
        eng_block = 1'b1;
        set_ops(1, 16'd2, 16'd10, 16'd1000);
        bus.req = 4'b0010;
        acc = '0;
        repeat (6) begin
            tick();
            acc = acc | bus.gnt;
        end
        check("blk_no_gnt", 32'(acc), 0);
        eng_block = 1'b0;
        tick();
        check("blk_gnt1", 32'(bus.gnt), 32'h2);
        wait_sig(1'b1, 50, v);
        check("blk_res", 32'(bus.res), 32'd24);
        bus.req = '0;
        tick();

        // ---- async reset while waiting for the engine ----
        set_ops(2, 16'd3, 16'd5, 16'd100);
        bus.req = 4'b0100;
        tick();
        check("ar_gnt2", 32'(bus.gnt), 32'h4);
        repeat (3) tick();          // now in WAIT_DONE, engine still running
        check("ar_busy_pre", 32'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;                          // no clock edge since reset asserted
        check("ar_busy", 32'(bus.busy), 0);
        check("ar_gnt",  32'(bus.gnt), 0);
        check("ar_done", 32'(bus.done), 0);
        check("ar_res",  32'(bus.res), 0);
        check("ar_eng_m", 32'(eng_m), 0);
        check("ar_start", 32'(eng_start), 0);
        check("ar_owner", 32'(bus.owner), 0);
        check("ar_lastc", bus.last_cycles, 0);
        d_snap = n_done_total;
        set_ops(1, 16'd5,  16'd3, 16'd13);
        set_ops(3, 16'd10, 16'd2, 16'd7);
        bus.req = 4'b1010;
        repeat (4) tick();
        check("ar_no_done", 32'(n_done_total - d_snap), 0);
        rst = 1'b1;
        wait_sig(1'b0, 10, v);
        check("ar_first_gnt", 32'(v), 32'h2);
        wait_sig(1'b1, 50, v);
        check("ar_done1", 32'(v), 32'h2);
        check("ar_res1",  32'(bus.res), 32'd8);
        bus.req = 4'b1000;
        wait_sig(1'b0, 10, v);
        check("ar_gnt3", 32'(v), 32'h8);
        wait_sig(1'b1, 50, v);
        check("ar_res3", 32'(bus.res), 2);
        bus.req = '0;
        repeat (2) tick();

        check("protocol", 32'(proto_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/modexp_arbiter.md
Name: modexp_arbiter

Overview:
- Shares one modexp engine among NREQ requesters (boot ROM verifier, 8051 crypto SFR port, debug port) using round-robin arbitration.
- Captures the winning requester's operands into holding registers, which keeps m/e/n stable for the whole engine run.
- Sequences the engine start/ready handshake and returns the result with a one-hot done pulse.
- Sits between the requester ports and a single modexp instance.

Parameters:
- W, 2048: operand/result width in bits; must match the engine instance.
- NREQ, 4: number of requesters (2..8).
- IDXW, 2: index width, equal to clog2(NREQ).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- req, input, NREQ: per-requester request level; held high until the matching done bit.
- req_m, input, NREQ*W: message operands; slice k = bits [k*W +: W].
- req_e, input, NREQ*W: exponent operands.
- req_n, input, NREQ*W: modulus operands.
- gnt, output, NREQ: one-hot, 1-cycle pulse when a requester's operands are captured.
- done, output, NREQ: one-hot, 1-cycle pulse when res is valid for that requester.
- res, output, W: result; holds its value until the next done.
- busy, output, 1: high whenever the FSM is not IDLE.
- owner, output, IDXW: index of the current or last granted requester.
- eng_start, output, 1: engine start.
- eng_ready, input, 1: engine ready (high while the engine is idle).
- eng_m, output, W: latched operand to the engine.
- eng_e, output, W: latched operand to the engine.
- eng_n, output, W: latched operand to the engine.
- eng_c, input, W: engine result.
- last_cycles, output, 32: cycle count of the last completed operation, from ISSUE to done inclusive; saturates at all-ones.

Behaviour:
- Reset (rst=0, async) values:
  - FSM in IDLE.
  - gnt=0, done=0, eng_start=0, busy=0.
  - res=0, eng_m/e/n=0, owner=0, last_cycles=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM has four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |req and eng_ready=1, select k = first set req bit scanning last+1, last+2, ... modulo NREQ.
  - Latch req_m/e/n slice k into eng_m/e/n, set owner=k and last=k, pulse gnt[k], go to ISSUE.
  - If eng_ready=0 or no req, stay in IDLE; no gnt.
- ISSUE: eng_start=1 for exactly this one cycle; clear the cycle counter to 1; go to WAIT_BUSY.
- WAIT_BUSY:
  - eng_start=0; wait for eng_ready=0, which confirms the engine accepted the start.
  - On eng_ready=0, go to WAIT_DONE.
  - The cycle counter increments every non-IDLE cycle.
- WAIT_DONE:
  - On eng_ready=1, register res<=eng_c, pulse done[owner], set last_cycles<=counter, go to IDLE.
- Latency:
  - gnt occurs in the cycle after req is seen in IDLE.
  - done occurs 1 cycle after the engine returns to ready.
  - Minimum gap from done to the next gnt is 1 cycle (the IDLE cycle).
- Operands:
  - Sampled only in the grant cycle.
  - Requester operands may change after gnt without effect.
  - eng_m/e/n stay constant from gnt until the next grant.
- Request dropped:
  - Before grant: no gnt is issued.
  - After grant: the operation completes and done still pulses; the result is simply unused.
- Fairness:
  - A requester that keeps req high after its done is served only after every other pending requester.
  - Simultaneous requests are resolved purely by pointer order.
- gnt and done are never asserted in the same cycle, and never more than one bit at a time.
- Reset mid-operation: all state returns to reset values immediately. Any done is lost. The engine is reset by its own system reset, not by this block.
- The counter saturates at 32'hFFFFFFFF.

Test Plan:
- W=16, NREQ=4; req=0001 with m=4, e=13, n=497 -> gnt[0] 1 cycle after req; eng_start a single pulse; done[0] with res=445; busy low after done.
- Three requests simultaneously: req=0111, with m=2, e=10, n=1000 on requester 1 -> grants in order 0,1,2; requester 1 res=24; exactly one done per requester; 1 idle cycle between done and the next gnt.
- Round-robin check: requester 0 holds req continuously while requester 3 asserts req during requester 0's operation -> the next grant is 3, not 0.
- Operand change after grant: alter req_m[0] one cycle after gnt[0] -> res equals the result for the original operand; eng_m unchanged.
- Engine busy: eng_ready=0 externally while req=0010 -> no gnt; release eng_ready -> gnt[1] next cycle.
- Async reset asserted in WAIT_DONE -> outputs take reset values without a clock edge; no done pulse; the first grant after reset goes to the lowest pending index.
